// File: rtl/bundler_stream.sv
`default_nettype none
// ============================================================================
// Module   : bundler_stream
// Brief    : Streaming bitwise-majority bundler for hypervector runs.
// Revision : 1.0
// ============================================================================
module bundler_stream #(
    parameter int DIM     = 1024,
    parameter int MAX_HVS = 16,
    localparam int CNT_W  = $clog2(MAX_HVS + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_hvs_i,
    input  logic [DIM-1:0]   tie_hv_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DIM-1:0]   in_hv_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DIM-1:0]   out_hv_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_TIE  = 3'd2,
        S_THR  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [DIM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          num_q, num_d;
    logic [DIM-1:0]            tie_q, tie_d;
    logic [DIM-1:0]            out_hv_q, out_hv_d;
    logic                      err_q, err_d;
    logic                      start_ok;
    logic [CNT_W:0]            n_eff;
    logic [CNT_W-1:0]          acc_inc;

    assign start_ok = (num_hvs_i != '0) && (num_hvs_i <= CNT_W'(MAX_HVS));
    // Even runs get the tie vector as one extra vote, so the effective count is odd.
    assign n_eff    = {1'b0, num_q} + {{CNT_W{1'b0}}, ~num_q[0]};
    assign acc_inc  = acc_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        num_d    = num_q;
        tie_d    = tie_q;
        out_hv_d = out_hv_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        num_d   = num_hvs_i;
                        tie_d   = tie_hv_i;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_ACC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else if (in_valid_i) begin
                    for (int i = 0; i < DIM; i++) begin
                        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, in_hv_i[i]};
                    end
                    acc_d = acc_inc;
                    if (acc_inc == num_q) begin
                        state_d = num_q[0] ? S_THR : S_TIE;
                    end
                end
            end
            S_TIE: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < DIM; i++) begin
                        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, tie_q[i]};
                    end
                    state_d = S_THR;
                end
            end
            S_THR: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < DIM; i++) begin
                        out_hv_d[i] = ({cnt_q[i], 1'b0} > n_eff);
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            num_q    <= '0;
            tie_q    <= '0;
            out_hv_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            num_q    <= num_d;
            tie_q    <= tie_d;
            out_hv_q <= out_hv_d;
            err_q    <= err_d;
        end
    end

    assign in_ready_o  = (state_q == S_ACC);
    assign out_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q != S_IDLE);
    assign out_hv_o    = out_hv_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bundler_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_bundler_stream
// Brief    : Directed self-checking bench for bundler_stream (DIM=8).
// Revision : 1.0
// ============================================================================
module tb_bundler_stream;

    localparam int DIM     = 8;
    localparam int MAX_HVS = 16;
    localparam int CNT_W   = $clog2(MAX_HVS + 2);

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] num_hvs_i;
    logic [DIM-1:0]   tie_hv_i;
    logic             abort_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [DIM-1:0]   in_hv_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [DIM-1:0]   out_hv_o;
    logic             busy_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;
    logic [DIM-1:0] sb_q[$];

    bundler_stream #(.DIM(DIM), .MAX_HVS(MAX_HVS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .num_hvs_i  (num_hvs_i),
        .tie_hv_i   (tie_hv_i),
        .abort_i    (abort_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_hv_i    (in_hv_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_hv_o   (out_hv_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input logic [DIM-1:0] tie);
        start_i   = 1'b1;
        num_hvs_i = CNT_W'(n);
        tie_hv_i  = tie;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic feed(input logic [DIM-1:0] v);
        in_valid_i = 1'b1;
        in_hv_i    = v;
        tick();
        in_valid_i = 1'b0;
    endtask

    // Majority reference: tie vector votes only on even runs.
    function automatic logic [DIM-1:0] majority(input logic [DIM-1:0] v[$], input logic [DIM-1:0] tie);
        logic [DIM-1:0] r;
        int n_eff;
        n_eff = v.size() + ((v.size() % 2 == 0) ? 1 : 0);
        for (int b = 0; b < DIM; b++) begin
            int c;
            c = 0;
            foreach (v[k]) c += v[k][b];
            if (v.size() % 2 == 0) c += tie[b];
            r[b] = (2 * c > n_eff);
        end
        return r;
    endfunction

    task automatic consume(input string tag);
        logic [DIM-1:0] exp;
        for (int i = 0; i < 20 && !out_valid_o; i++) tick();
        chk({tag, "_valid"}, out_valid_o, 1'b1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk({tag, "_hv"}, out_hv_o, exp);
        out_ready_i = 1'b1;
        tick();
        chk({tag, "_drop"}, out_valid_o, 1'b0);
        chk({tag, "_idle"}, busy_o, 1'b0);
    endtask

    task automatic odd_feed();
        feed(8'hAA); feed(8'hCC); feed(8'hF0); feed(8'hFF); feed(8'h00);
    endtask

    initial begin
        logic [DIM-1:0] rv[$];
        logic [DIM-1:0] rtie;

        rst = 1'b1; start_i = 1'b0; num_hvs_i = '0; tie_hv_i = '0; abort_i = 1'b0;
        in_valid_i = 1'b0; in_hv_i = '0; out_ready_i = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_out_hv", out_hv_o, 8'h00);
        rst = 1'b0;
        tick();

        // Odd run: result two cycles after the last accept
        sb_q.push_back(8'hE8);
        start_run(5, 8'hFF);
        chk("odd_in_ready", in_ready_o, 1'b1);
        odd_feed();
        chk("odd_ready_low", in_ready_o, 1'b0);
        chk("odd_k1_valid", out_valid_o, 1'b0);
        tick();
        chk("odd_k2_valid", out_valid_o, 1'b1);
        consume("odd");

        // Even run: tie vector votes, three cycles after the last accept
        sb_q.push_back(8'hEE);
        start_run(4, 8'h0F);
        feed(8'hAA); feed(8'hCC); feed(8'hF0); feed(8'hFF);
        chk("even_k1_valid", out_valid_o, 1'b0);
        tick();
        chk("even_k2_valid", out_valid_o, 1'b0);
        tick();
        chk("even_k3_valid", out_valid_o, 1'b1);
        consume("even");

        // Single vector with an input gap
        sb_q.push_back(8'h5A);
        start_run(1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("gap_in_ready", in_ready_o, 1'b1);
            tick();
        end
        feed(8'h5A);
        chk("single_ready_low", in_ready_o, 1'b0);
        consume("single");

        // Backpressure with a stray start during OUT
        out_ready_i = 1'b0;
        sb_q.push_back(8'hE8);
        start_run(5, 8'h00);
        odd_feed();
        tick();
        for (int i = 0; i < 5; i++) begin
            start_i   = (i == 2);
            num_hvs_i = CNT_W'(3);
            chk("bp_valid", out_valid_o, 1'b1);
            chk("bp_hv", out_hv_o, 8'hE8);
            chk("bp_err", err_o, 1'b0);
            tick();
        end
        start_i = 1'b0;
        consume("bp");
        chk("bp_retain_hv", out_hv_o, 8'hE8);

        // Abort mid-ACC, then a clean run
        start_run(5, 8'h00);
        feed(8'hFF); feed(8'hFF);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_in_ready", in_ready_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_valid", out_valid_o, 1'b0);
            tick();
        end
        sb_q.push_back(8'hE8);
        start_run(5, 8'hFF);
        odd_feed();
        consume("recover");

        // Rejected starts
        start_run(0, 8'h00);
        chk("err0_pulse", err_o, 1'b1);
        chk("err0_busy", busy_o, 1'b0);
        tick();
        chk("err0_clear", err_o, 1'b0);
        start_run(17, 8'h00);
        chk("err17_pulse", err_o, 1'b1);
        chk("err17_busy", busy_o, 1'b0);
        tick();

        // Random even run against the reference model
        rtie = DIM'($urandom);
        rv = {};
        for (int i = 0; i < 6; i++) rv.push_back(DIM'($urandom));
        sb_q.push_back(majority(rv, rtie));
        start_run(6, rtie);
        foreach (rv[k]) feed(rv[k]);
        consume("rand_even");

        // Start beats abort in IDLE; then asynchronous reset mid-ACC
        start_i = 1'b1; abort_i = 1'b1; num_hvs_i = CNT_W'(5); tie_hv_i = 8'h00;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_wins_busy", busy_o, 1'b1);
        feed(8'hAA); feed(8'hCC);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_in_ready", in_ready_o, 1'b0);
        chk("arst_out_valid", out_valid_o, 1'b0);
        chk("arst_out_hv", out_hv_o, 8'h00);
        chk("arst_err", err_o, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bundler_stream.md
Name: bundler_stream

Overview:
- Streaming majority bundler for hypervectors: accepts a run of num_hvs DIM-bit hypervectors, one per handshake.
- Accumulates per-bit vote counts, then emits the bitwise-majority hypervector.
- Even-count runs are resolved with a tie-break hypervector that counts as one extra vote.
- Successor to the single-bit bundler: full vector width, run-time count up to MAX_HVS, valid/ready on both sides. Sits between the encoder and the associative memory.

Parameters:
- DIM, 1024, hypervector width in bits.
- MAX_HVS, 16, largest run length supported.
- CNT_W, $clog2(MAX_HVS+2), per-bit counter width (derived; must not be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- num_hvs  in  CNT_W  run length, sampled on an accepted start.
- tie_hv  in  DIM  tie-break vector, sampled on an accepted start.
- abort  in  1  synchronous cancel of the current run.
- in_valid  in  1  input hypervector valid.
- in_ready  out  1  block accepts an input hypervector.
- in_hv  in  DIM  input hypervector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_hv  out  DIM  bundled result.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all counters 0, out_hv=0, out_valid=0, in_ready=0, busy=0, err=0, latched num_hvs/tie_hv=0.
- FSM states: IDLE, ACC, TIE, THR, OUT.
- IDLE:
  - start with 1<=num_hvs<=MAX_HVS: latch num_hvs and tie_hv, clear all counters and the accept count, go to ACC.
  - start with num_hvs==0 or num_hvs>MAX_HVS: err=1 for one cycle, stay in IDLE.
  - in_valid is ignored in IDLE.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: counter[i] += in_hv[i] for every bit i; accepted count increments.
  - On the num_hvs-th accept: go to TIE if num_hvs is even, else THR.
  - in_ready is 0 from the cycle after the last accept.
- TIE (one cycle, even runs only): counter[i] += tie_hv[i]; effective count n_eff = num_hvs+1. For odd runs n_eff = num_hvs.
- THR (one cycle): out_hv[i] = (2*counter[i] > n_eff). All arithmetic is unsigned, with counters wide enough never to overflow; go to OUT.
- OUT:
  - out_valid=1; out_hv is held stable while out_valid is high.
  - On out_valid&out_ready: out_valid drops the next cycle and the FSM returns to IDLE.
  - out_hv retains its last value afterwards.
- Latency, last input accept at cycle k:
  - odd run: out_valid high from cycle k+2;
  - even run: out_valid high from cycle k+3.
  - Fastest back-to-back throughput is limited by one IDLE cycle between runs.
- Start while busy is ignored (no err, no effect).
- abort in ACC, TIE or THR: return to IDLE next cycle, drop in_ready, clear counters; out_hv is unchanged and out_valid is not raised.
- abort in OUT is ignored: the result must be consumed.
- abort and start in the same IDLE cycle: start wins.
- Reset mid-run discards all partial state; there is no output pulse.

Test Plan (DIM=8, MAX_HVS=16):
- Odd run: reset, start num_hvs=5, tie_hv=8'hFF, feed 8'hAA, 8'hCC, 8'hF0, 8'hFF, 8'h00 on consecutive cycles, out_ready=1 -> out_valid two cycles after the last accept; out_hv=8'hE8; tie_hv has no effect.
- Even run: start num_hvs=4, tie_hv=8'h0F, feed 8'hAA, 8'hCC, 8'hF0, 8'hFF -> out_hv=8'hEE three cycles after the last accept.
- Single vector plus input gaps: num_hvs=1, in_valid raised 3 cycles late with 8'h5A -> out_hv=8'h5A; in_ready stays high through the gap and is low from the cycle after the accept.
- Backpressure: hold out_ready=0 for 5 cycles and pulse start meanwhile -> out_valid and out_hv=8'hE8 stable, start ignored; out_valid drops the cycle after out_ready=1.
- Abort and recovery: num_hvs=5, feed 8'hFF, 8'hFF, then abort -> IDLE next cycle, out_valid never rises; a fresh odd-run sequence then yields 8'hE8, proving counters were cleared.
- Errors and reset: start with num_hvs=0 -> err pulse, busy stays 0. Start with num_hvs=17 -> err pulse. Assert rst mid-ACC -> all outputs 0 immediately, without waiting for a clock edge.
